// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM receive path: FSM state encodings and default widths.
package pwm_pkg;

    localparam int DEF_COUNT_WIDTH = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchroniser for an asynchronous line, plus one-cycle rise/fall pulses on the synchronised level.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_s,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_d};
            s_d    <= sync_q[SYNC_STAGES-1];
        end
    end

    assign o_s    = sync_q[SYNC_STAGES-1];
    assign o_rise = o_s & ~s_d;
    assign o_fall = ~o_s & s_d;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of each full cycle on a PWM line, in clock cycles,
// and flags a timeout when the line stops toggling.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
    parameter int MAX_COUNT   = 4095
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_pwm,
    output logic                   o_level,
    output logic [COUNT_WIDTH-1:0] o_period,
    output logic [COUNT_WIDTH-1:0] o_high,
    output logic                   o_valid,
    output logic                   o_timeout,
    output logic                   o_stuck
);

    localparam logic [COUNT_WIDTH-1:0] MAX_C = COUNT_WIDTH'(MAX_COUNT);

    logic                   s, rise, fall;
    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] cnt_q, r_high;
    logic                   at_max, ld_high, ld_out, tmo;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_d    (i_pwm),
        .o_s    (s),
        .o_rise (rise),
        .o_fall (fall)
    );

    assign at_max  = (cnt_q == MAX_C);
    assign o_level = s;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // An edge always takes priority over the saturation check, so a cycle of
    // exactly MAX_COUNT clocks is still measured.
    always_comb begin
        state_d = state_q;
        ld_high = 1'b0;
        ld_out  = 1'b0;
        tmo     = 1'b0;
        case (state_q)
            ST_IDLE: if (rise) state_d = ST_HIGH;
            ST_HIGH: begin
                if (fall) begin
                    ld_high = 1'b1;
                    state_d = ST_LOW;
                end else if (at_max) begin
                    tmo     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    ld_out  = 1'b1;
                    state_d = ST_HIGH;
                end else if (at_max) begin
                    tmo     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q     <= '0;
            r_high    <= '0;
            o_period  <= '0;
            o_high    <= '0;
            o_valid   <= 1'b0;
            o_timeout <= 1'b0;
            o_stuck   <= 1'b0;
        end else begin
            o_valid   <= ld_out;
            o_timeout <= tmo;
            if (rise)
                cnt_q <= COUNT_WIDTH'(1);
            else if (tmo)
                cnt_q <= '0;
            else if (state_q != ST_IDLE && !at_max)
                cnt_q <= cnt_q + 1'b1;
            if (ld_high)
                r_high <= cnt_q;
            if (ld_out) begin
                o_period <= cnt_q;
                o_high   <= r_high;
            end
            if (tmo)
                o_stuck <= s;
        end
    end

endmodule
